// File: rtl/core_mem_system.sv
// core_mem_system: loader-filled imem/dmem responder for the 8-bit core, with run-cycle count and self-jump halt
module core_mem_system #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int HALT_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] data_i,
  output logic              core_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              restart,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int SW = $clog2(HALT_CYC + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] ld_addr_q, ld_addr_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic pc_vld_q, pc_vld_d;
  logic [DATA_W-1:0] imem [2**ADDR_W];
  logic [DATA_W-1:0] dmem [2**ADDR_W];
  logic ld_acc, imem_we, dmem_we;
  logic [ADDR_W-1:0] dmem_wa;
  logic [DATA_W-1:0] dmem_wd;
  always_comb begin
    state_d = state_q;
    ld_addr_d = ld_addr_q;
    stall_cnt_d = stall_cnt_q;
    cycle_count_d = cycle_count_q;
    pc_d = pc;
    pc_vld_d = 1'b0;
    ld_acc = state_q == LOAD && ld_valid;
    imem_we = ld_acc && !ld_addr_q[ADDR_W];
    dmem_we = (ld_acc && ld_addr_q[ADDR_W]) || (state_q == RUN && wr_mem);
    dmem_wa = state_q == RUN ? address : ld_addr_q[ADDR_W-1:0];
    dmem_wd = state_q == RUN ? data_o : ld_data;
    if (state_q == IDLE) begin
      ld_addr_d = '0;
      cycle_count_d = '0;
      stall_cnt_d = '0;
      if (ld_valid) state_d = LOAD;
    end
    if (ld_acc) begin
      ld_addr_d = ld_addr_q + 1'b1;
      if (ld_last || &ld_addr_q) state_d = RUN;
    end
    if (state_q == RUN) begin
      cycle_count_d = &cycle_count_q ? cycle_count_q : cycle_count_q + 1'b1;
      pc_vld_d = 1'b1;
      stall_cnt_d = (pc_vld_q && pc == pc_q) ? stall_cnt_q + 1'b1 : '0;
      if (stall_cnt_d == SW'(HALT_CYC)) state_d = HALT;
    end
    if (restart) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (!reset) begin
      state_q <= IDLE;
      ld_addr_q <= '0;
      stall_cnt_q <= '0;
      cycle_count_q <= '0;
      pc_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_addr_q <= ld_addr_d;
      stall_cnt_q <= stall_cnt_d;
      cycle_count_q <= cycle_count_d;
      pc_vld_q <= pc_vld_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && imem_we) imem[ld_addr_q[ADDR_W-1:0]] <= ld_data;
    if (reset && dmem_we) dmem[dmem_wa] <= dmem_wd;
  end
  assign running = state_q == RUN;
  assign halted = state_q == HALT;
  assign core_rst = !running;
  assign ld_ready = state_q == LOAD;
  assign instruction = running ? imem[pc] : '0;
  assign data_i = (running && rd_mem) ? dmem[address] : '0;
  assign dbg_data = dmem[dbg_addr];
  assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_core_mem_system.sv
// tb_core_mem_system: directed self-checking bench for core_mem_system
module tb_core_mem_system;
  logic clk = 0, reset = 0;
  logic [4:0] pc = 0, address = 0, dbg_addr = 0;
  logic [7:0] instruction, data_i, data_o = 0, ld_data = 0, dbg_data;
  logic rd_mem = 0, wr_mem = 0, core_rst, ld_valid = 0, ld_ready, ld_last = 0, restart = 0;
  logic running, halted;
  logic [15:0] cycle_count;
  int errors = 0, checks = 0;
  core_mem_system dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction), .rd_mem(rd_mem),
    .wr_mem(wr_mem), .address(address), .data_o(data_o), .data_i(data_i),
    .core_rst(core_rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .restart(restart), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .running(running), .halted(halted), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    tick();
    check("t1_core_rst", core_rst, 1);
    check("t1_ld_ready", ld_ready, 0);
    check("t1_running", running, 0);
    check("t1_halted", halted, 0);
    check("t1_cycles", cycle_count, 0);
    reset = 1;
    ld_valid = 1;
    ld_data = 8'hA1;
    tick();
    check("t2_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 0;
    tick();
    ld_valid = 1;
    ld_data = 8'hB2;
    tick();
    ld_valid = 0;
    tick();
    check("t2_still_load", core_rst, 1);
    ld_valid = 1;
    ld_data = 8'hC3;
    ld_last = 1;
    tick();
    ld_valid = 0;
    ld_last = 0;
    check("t2_running", running, 1);
    check("t2_core_rst", core_rst, 0);
    check("t2_ld_ready", ld_ready, 0);
    pc = 0; #1 check("t2_imem0", instruction, 8'hA1);
    pc = 1; #1 check("t2_imem1", instruction, 8'hB2);
    pc = 2; #1 check("t2_imem2", instruction, 8'hC3);
    tick();
    check("t2_cycles", cycle_count, 1);
    restart = 1;
    tick();
    restart = 0;
    check("t2_restart_idle", running, 0);
    check("t2_restart_rst", core_rst, 1);
    check("t2_idle_instr", instruction, 0);
    ld_valid = 1;
    tick();
    for (int i = 0; i < 64; i++) begin
      ld_data = 8'(i);
      check("t3_ready", ld_ready, 1);
      tick();
    end
    ld_valid = 0;
    check("t3_auto_run", running, 1);
    check("t3_cycles0", cycle_count, 0);
    dbg_addr = 5; #1 check("t3_dbg5", dbg_data, 8'h25);
    pc = 4; #1 check("t3_imem4", instruction, 8'h04);
    pc = 0;
    wr_mem = 1;
    address = 7;
    data_o = 8'h11;
    dbg_addr = 7;
    tick();
    check("t4_pre_write", dbg_data, 8'h11);
    pc = 1;
    rd_mem = 1;
    data_o = 8'h5A;
    #1 check("t4_rd_old", data_i, 8'h11);
    check("t4_dbg_old", dbg_data, 8'h11);
    tick();
    wr_mem = 0;
    check("t4_dbg_new", dbg_data, 8'h5A);
    check("t4_rd_new", data_i, 8'h5A);
    check("t4_cycles", cycle_count, 2);
    rd_mem = 0;
    #1 check("t4_rd_off", data_i, 0);
    for (int i = 0; i < 4; i++) begin
      pc = 5'(i);
      tick();
    end
    check("t5_run_before_hold", running, 1);
    tick();
    check("t5_run_one_equal", running, 1);
    tick();
    check("t5_halted", halted, 1);
    check("t5_core_rst", core_rst, 1);
    check("t5_running", running, 0);
    check("t5_cycles", cycle_count, 8);
    check("t5_instr0", instruction, 0);
    wr_mem = 1;
    rd_mem = 1;
    data_o = 8'hEE;
    #1 check("t5_data_i0", data_i, 0);
    tick();
    tick();
    wr_mem = 0;
    rd_mem = 0;
    check("t5_dmem_frozen", dbg_data, 8'h5A);
    check("t5_cycles_held", cycle_count, 8);
    check("t5_still_halted", halted, 1);
    restart = 1;
    tick();
    restart = 0;
    check("t6_idle_halted", halted, 0);
    check("t6_idle_rst", core_rst, 1);
    ld_valid = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      ld_data = 8'h80 + 8'(i);
      tick();
    end
    ld_data = 8'h77;
    ld_last = 1;
    restart = 1;
    tick();
    restart = 0;
    ld_last = 0;
    ld_valid = 0;
    check("t6_no_run", running, 0);
    check("t6_no_ready", ld_ready, 0);
    tick();
    check("t6_stay_idle", ld_ready, 0);
    ld_valid = 1;
    tick();
    ld_data = 8'h99;
    ld_last = 1;
    tick();
    ld_valid = 0;
    ld_last = 0;
    check("t6_run", running, 1);
    pc = 10; #1 check("t6_byte_written", instruction, 8'h77);
    pc = 0; #1 check("t6_imem0", instruction, 8'h99);
    pc = 1; #1 check("t6_imem1", instruction, 8'h81);
    tick();
    check("t6_cycles1", cycle_count, 1);
    reset = 0;
    tick();
    reset = 1;
    check("t6_reset_idle", running, 0);
    check("t6_reset_rst", core_rst, 1);
    check("t6_reset_cycles", cycle_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
